// File: rtl/pll_reconfig_sequencer.sv
// Drives one full PLL reconfiguration through the reconfig controller's Avalon-MM
// management slave: mode, N, M, C, optional phase shift, start, then lock wait.
module pll_reconfig_sequencer #(
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned LOCK_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_m,
  input  logic [4:0]  cfg_c_sel,
  input  logic [17:0] cfg_c,
  input  logic        cfg_dps_en,
  input  logic [4:0]  cfg_dps_sel,
  input  logic        cfg_dps_updn,
  input  logic [15:0] cfg_dps_steps,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        mgmt_read,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);

  localparam int unsigned CW   = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned CNTW = 18;
  localparam int unsigned AW   = 6;
  localparam int unsigned DW   = 32;

  typedef enum logic [3:0] {
    IDLE, WR_MODE, WR_N, WR_M, WR_C, WR_DPS, WR_START, WAIT_LOCK, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   n_q, n_d, m_q, m_d, c_q, c_d;
  logic [4:0]        c_sel_q, c_sel_d, dps_sel_q, dps_sel_d;
  logic              dps_en_q, dps_en_d, dps_updn_q, dps_updn_d;
  logic [15:0]       dps_steps_q, dps_steps_d;
  logic [CW-1:0]     stable_cnt_q, stable_cnt_d, timeout_cnt_q, timeout_cnt_d;
  logic              locked_meta_q, locked_sync_q;
  logic              busy_q, busy_d, done_q, done_d, cfg_ready_q, cfg_ready_d;
  logic              timeout_err_q, timeout_err_d;
  logic              mgmt_write_q, mgmt_write_d;
  logic [AW-1:0]     mgmt_address_q, mgmt_address_d;
  logic [DW-1:0]     mgmt_writedata_q, mgmt_writedata_d;
  logic              write_done;

  assign write_done = mgmt_write_q && !mgmt_waitrequest;

  // State register, latched request, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      n_q              <= '0;
      m_q              <= '0;
      c_q              <= '0;
      c_sel_q          <= '0;
      dps_en_q         <= 1'b0;
      dps_sel_q        <= '0;
      dps_updn_q       <= 1'b0;
      dps_steps_q      <= '0;
      stable_cnt_q     <= '0;
      timeout_cnt_q    <= '0;
      locked_meta_q    <= 1'b0;
      locked_sync_q    <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      cfg_ready_q      <= 1'b0;
      timeout_err_q    <= 1'b0;
      mgmt_write_q     <= 1'b0;
      mgmt_address_q   <= '0;
      mgmt_writedata_q <= '0;
    end else begin
      state_q          <= state_d;
      n_q              <= n_d;
      m_q              <= m_d;
      c_q              <= c_d;
      c_sel_q          <= c_sel_d;
      dps_en_q         <= dps_en_d;
      dps_sel_q        <= dps_sel_d;
      dps_updn_q       <= dps_updn_d;
      dps_steps_q      <= dps_steps_d;
      stable_cnt_q     <= stable_cnt_d;
      timeout_cnt_q    <= timeout_cnt_d;
      locked_meta_q    <= pll_locked;
      locked_sync_q    <= locked_meta_q;
      busy_q           <= busy_d;
      done_q           <= done_d;
      cfg_ready_q      <= cfg_ready_d;
      timeout_err_q    <= timeout_err_d;
      mgmt_write_q     <= mgmt_write_d;
      mgmt_address_q   <= mgmt_address_d;
      mgmt_writedata_q <= mgmt_writedata_d;
    end
  end

  // Next-state logic; bus outputs are derived from the next state so they
  // change on the same edge that completes the previous write.
  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    m_d           = m_q;
    c_d           = c_q;
    c_sel_d       = c_sel_q;
    dps_en_d      = dps_en_q;
    dps_sel_d     = dps_sel_q;
    dps_updn_d    = dps_updn_q;
    dps_steps_d   = dps_steps_q;
    stable_cnt_d  = '0;
    timeout_cnt_d = '0;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        if (cfg_valid && cfg_ready_q) begin
          n_d           = cfg_n;
          m_d           = cfg_m;
          c_d           = cfg_c;
          c_sel_d       = cfg_c_sel;
          dps_en_d      = cfg_dps_en;
          dps_sel_d     = cfg_dps_sel;
          dps_updn_d    = cfg_dps_updn;
          dps_steps_d   = cfg_dps_steps;
          timeout_err_d = 1'b0;
          state_d       = WR_MODE;
        end
      end
      WR_MODE:  if (write_done) state_d = WR_N;
      WR_N:     if (write_done) state_d = WR_M;
      WR_M:     if (write_done) state_d = WR_C;
      WR_C:     if (write_done) state_d = dps_en_q ? WR_DPS : WR_START;
      WR_DPS:   if (write_done) state_d = WR_START;
      WR_START: if (write_done) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        stable_cnt_d  = locked_sync_q ? stable_cnt_q + CW'(1) : '0;
        timeout_cnt_d = timeout_cnt_q + CW'(1);
        // A stable lock takes priority over a coincident timeout
        if (stable_cnt_d == CW'(LOCK_STABLE)) begin
          timeout_err_d = 1'b0;
          state_d       = DONE;
        end else if (timeout_cnt_d == CW'(LOCK_TIMEOUT)) begin
          timeout_err_d = 1'b1;
          state_d       = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mgmt_write_d     = 1'b0;
    mgmt_address_d   = '0;
    mgmt_writedata_d = '0;
    case (state_d)
      WR_MODE: begin
        mgmt_write_d     = 1'b1;
        mgmt_address_d   = AW'(6'h00);
      end
      WR_N: begin
        mgmt_write_d     = 1'b1;
        mgmt_address_d   = AW'(6'h03);
        mgmt_writedata_d = {14'b0, n_d};
      end
      WR_M: begin
        mgmt_write_d     = 1'b1;
        mgmt_address_d   = AW'(6'h04);
        mgmt_writedata_d = {14'b0, m_d};
      end
      WR_C: begin
        mgmt_write_d     = 1'b1;
        mgmt_address_d   = AW'(6'h05);
        mgmt_writedata_d = {9'b0, c_sel_d, c_d};
      end
      WR_DPS: begin
        mgmt_write_d     = 1'b1;
        mgmt_address_d   = AW'(6'h06);
        mgmt_writedata_d = {10'b0, dps_updn_d, dps_sel_d, dps_steps_d};
      end
      WR_START: begin
        mgmt_write_d     = 1'b1;
        mgmt_address_d   = AW'(6'h02);
        mgmt_writedata_d = DW'(1);
      end
      default: ;
    endcase

    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    cfg_ready_d = (state_d == IDLE);
  end

  assign cfg_ready      = cfg_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout_err    = timeout_err_q;
  assign mgmt_read      = 1'b0;
  assign mgmt_write     = mgmt_write_q;
  assign mgmt_address   = mgmt_address_q;
  assign mgmt_writedata = mgmt_writedata_q;

endmodule
